// File: rtl/timer_pkg.sv
// Shared types and constants for the multi-channel countdown timer.
package timer_pkg;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, EXPIRED} state_t;

  localparam int SEC_W = 6;
  localparam logic [SEC_W-1:0] SEC_MAX = 6'd59;

  function automatic logic [SEC_W-1:0] clamp_sec(input logic [SEC_W-1:0] s);
    return (s > SEC_MAX) ? SEC_MAX : s;
  endfunction

endpackage

// File: rtl/countdown_timer_mc_tick_gen.sv
// Free-running divider: tick is high while the counter sits at TICK_DIV-1.
module tick_gen #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (cnt_q == LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/countdown_timer_mc.sv
// NUM_CH independent min:sec countdown channels sharing one divided tick.
// Optional reload-on-expiry mode is enabled by defining TIMER_AUTORELOAD_EN.
module countdown_timer_mc
  import timer_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int TICK_DIV = 50_000_000,
  parameter int MIN_W    = 6
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_CH-1:0]         load,
  input  logic [MIN_W-1:0]          load_min,
  input  logic [SEC_W-1:0]          load_sec,
  input  logic [NUM_CH-1:0]         start,
  input  logic [NUM_CH-1:0]         pause,
  input  logic [NUM_CH-1:0]         clear,
`ifdef TIMER_AUTORELOAD_EN
  input  logic [NUM_CH-1:0]         auto_reload,
`endif
  output logic [NUM_CH*MIN_W-1:0]   count_minutes,
  output logic [NUM_CH*SEC_W-1:0]   count_seconds,
  output logic [NUM_CH-1:0]         running,
  output logic [NUM_CH-1:0]         done,
  output logic [NUM_CH-1:0]         expired
);

  logic tick;
  logic [SEC_W-1:0] sec_clamped;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  assign sec_clamped = clamp_sec(load_sec);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    state_t            state_q, state_d;
    logic [MIN_W-1:0]  min_q, min_d, rmin_q, rmin_d;
    logic [SEC_W-1:0]  sec_q, sec_d, rsec_q, rsec_d;
    logic              run_q, done_q, exp_q, exp_d;
    logic              ar;

`ifdef TIMER_AUTORELOAD_EN
    assign ar = auto_reload[i];
`else
    assign ar = 1'b0;
`endif

    // Strobes are a strict priority chain; an asserted higher strobe
    // consumes the cycle, so a tick coinciding with any command is dropped.
    always_comb begin
      state_d = state_q;
      min_d   = min_q;
      sec_d   = sec_q;
      rmin_d  = rmin_q;
      rsec_d  = rsec_q;
      exp_d   = 1'b0;
      if (clear[i]) begin
        state_d = IDLE;
        min_d   = '0;
        sec_d   = '0;
      end else if (load[i]) begin
        rmin_d = load_min;
        rsec_d = sec_clamped;
        min_d  = load_min;
        sec_d  = sec_clamped;
        if (state_q == EXPIRED) state_d = IDLE;
      end else if (pause[i]) begin
        if (state_q == RUN) state_d = PAUSE;
      end else if (start[i]) begin
        if (state_q != RUN) begin
          if (state_q == EXPIRED) begin
            min_d = rmin_q;
            sec_d = rsec_q;
          end
          if (min_d == '0 && sec_d == '0) begin
            state_d = EXPIRED;
            exp_d   = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
      end else if (tick && state_q == RUN) begin
        if (sec_q != '0) begin
          sec_d = sec_q - 1'b1;
        end else begin
          min_d = min_q - 1'b1;
          sec_d = SEC_MAX;
        end
        if (min_d == '0 && sec_d == '0) begin
          exp_d = 1'b1;
          if (ar && !(rmin_q == '0 && rsec_q == '0)) begin
            min_d = rmin_q;
            sec_d = rsec_q;
          end else begin
            state_d = EXPIRED;
          end
        end
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state_q <= IDLE;
        min_q   <= '0;
        sec_q   <= '0;
        rmin_q  <= '0;
        rsec_q  <= '0;
        run_q   <= 1'b0;
        done_q  <= 1'b0;
        exp_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        min_q   <= min_d;
        sec_q   <= sec_d;
        rmin_q  <= rmin_d;
        rsec_q  <= rsec_d;
        run_q   <= (state_d == RUN);
        done_q  <= (state_d == EXPIRED);
        exp_q   <= exp_d;
      end
    end

    assign count_minutes[i*MIN_W +: MIN_W] = min_q;
    assign count_seconds[i*SEC_W +: SEC_W] = sec_q;
    assign running[i] = run_q;
    assign done[i]    = done_q;
    assign expired[i] = exp_q;
  end

endmodule

// File: tb/tb_countdown_timer_mc.sv
// Bench for countdown_timer_mc: table vectors, directed corner sequences and
// random strobes checked against a total-seconds reference model.
module tb_countdown_timer_mc;

  localparam int NUM_CH   = 2;
  localparam int TICK_DIV = 4;
  localparam int MIN_W    = 6;
  localparam int W        = MIN_W + 9;

  logic clk = 1'b0;
  logic reset;
  logic [NUM_CH-1:0] load, start, pause, clear, auto_reload;
  logic [MIN_W-1:0]  load_min;
  logic [5:0]        load_sec;
  logic [NUM_CH*MIN_W-1:0] count_minutes;
  logic [NUM_CH*6-1:0]     count_seconds;
  logic [NUM_CH-1:0] running, done, expired;

  int errors = 0;
  int checks = 0;

  // reference model: count held as total seconds; idle and paused are alike
  int m_cnt [NUM_CH];
  int m_rel [NUM_CH];
  bit m_run [NUM_CH];
  bit m_done[NUM_CH];
  bit m_exp [NUM_CH];
  int edge_n;
  bit last_tick;
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic       ld, st, pa, cl;
    logic [5:0] lmin, lsec;
    logic [5:0] emin, esec;
    logic       erun, edone, eexp;
  } vec_t;
  vec_t vecs[14];

  // clock/reset
  always #5 clk = ~clk;

  countdown_timer_mc #(
    .NUM_CH(NUM_CH), .TICK_DIV(TICK_DIV), .MIN_W(MIN_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .load          (load),
    .load_min      (load_min),
    .load_sec      (load_sec),
    .start         (start),
    .pause         (pause),
    .clear         (clear),
`ifdef TIMER_AUTORELOAD_EN
    .auto_reload   (auto_reload),
`endif
    .count_minutes (count_minutes),
    .count_seconds (count_seconds),
    .running       (running),
    .done          (done),
    .expired       (expired)
  );

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h (min,sec,run,done,exp) t=%0t", name, got, want, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_cnt[c] = 0; m_rel[c] = 0; m_run[c] = 0; m_done[c] = 0; m_exp[c] = 0;
    end
    edge_n = 0;
    exp_q.delete();
  endtask

  task automatic model_step();
    bit tk;
    bit ar;
    int lt;
    edge_n++;
    tk = ((edge_n - 1) % TICK_DIV) == (TICK_DIV - 1);
    last_tick = tk;
    lt = int'(load_min) * 60 + ((load_sec > 6'd59) ? 59 : int'(load_sec));
    for (int c = 0; c < NUM_CH; c++) begin
      ar = 1'b0;
`ifdef TIMER_AUTORELOAD_EN
      ar = auto_reload[c];
`endif
      m_exp[c] = 0;
      if (clear[c]) begin
        m_cnt[c] = 0; m_run[c] = 0; m_done[c] = 0;
      end else if (load[c]) begin
        m_cnt[c] = lt; m_rel[c] = lt; m_done[c] = 0;
      end else if (pause[c]) begin
        m_run[c] = 0;
      end else if (start[c]) begin
        if (!m_run[c]) begin
          if (m_done[c]) m_cnt[c] = m_rel[c];
          m_done[c] = 0;
          if (m_cnt[c] == 0) begin
            m_done[c] = 1; m_exp[c] = 1;
          end else begin
            m_run[c] = 1;
          end
        end
      end else if (tk && m_run[c]) begin
        m_cnt[c]--;
        if (m_cnt[c] == 0) begin
          m_exp[c] = 1;
          if (ar && m_rel[c] != 0) m_cnt[c] = m_rel[c];
          else begin
            m_run[c] = 0; m_done[c] = 1;
          end
        end
      end
      exp_q.push_back({MIN_W'(m_cnt[c] / 60), 6'(m_cnt[c] % 60), m_run[c], m_done[c], m_exp[c]});
    end
  endtask

  function automatic logic [W-1:0] dut_ch(input int c);
    return {count_minutes[c*MIN_W +: MIN_W], count_seconds[c*6 +: 6], running[c], done[c], expired[c]};
  endfunction

  // driver: one clock with the currently applied strobes, then scoreboard
  task automatic step();
    logic [W-1:0] want;
    model_step();
    @(posedge clk);
    #1;
    for (int c = 0; c < NUM_CH; c++) begin
      want = exp_q.pop_front();
      check($sformatf("model_ch%0d", c), dut_ch(c), want);
    end
  endtask

  task automatic idle_inputs();
    load = '0; start = '0; pause = '0; clear = '0;
  endtask

  initial begin
    int ticks;
    int pulses;
    bit seen;
    bit ar_ok;

    vecs[0]  = '{1,0,0,0, 2,63,  2,59, 0,0,0};
    vecs[1]  = '{1,1,0,1, 5,5,   0,0,  0,0,0};
    vecs[2]  = '{0,1,0,0, 0,0,   0,0,  0,1,1};
    vecs[3]  = '{0,1,0,0, 0,0,   2,59, 1,0,0};
    vecs[4]  = '{0,0,1,0, 0,0,   2,59, 0,0,0};
    vecs[5]  = '{0,0,0,0, 0,0,   2,59, 0,0,0};
    vecs[6]  = '{1,0,0,0, 0,5,   0,5,  0,0,0};
    vecs[7]  = '{0,0,0,1, 0,0,   0,0,  0,0,0};
    vecs[8]  = '{0,1,0,0, 0,0,   0,0,  0,1,1};
    vecs[9]  = '{0,0,0,0, 0,0,   0,0,  0,1,0};
    vecs[10] = '{1,0,0,0, 1,10,  1,10, 0,0,0};
    vecs[11] = '{1,0,0,0, 0,0,   0,0,  0,0,0};
    vecs[12] = '{0,1,0,0, 0,0,   0,0,  0,1,1};
    vecs[13] = '{0,0,0,1, 0,0,   0,0,  0,0,0};

    reset = 1'b1;
    idle_inputs();
    auto_reload = '0;
    load_min = '0;
    load_sec = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_ch0", dut_ch(0), '0);
    check("reset_ch1", dut_ch(1), '0);
    reset = 1'b0;

    // table: ch1 control corners where ticks cannot interfere
    foreach (vecs[k]) begin
      idle_inputs();
      load[1] = vecs[k].ld; start[1] = vecs[k].st;
      pause[1] = vecs[k].pa; clear[1] = vecs[k].cl;
      load_min = vecs[k].lmin; load_sec = vecs[k].lsec;
      step();
      check($sformatf("table_%0d", k), dut_ch(1),
            {vecs[k].emin, vecs[k].esec, vecs[k].erun, vecs[k].edone, vecs[k].eexp});
      check($sformatf("table_%0d_ch0", k), dut_ch(0), '0);
    end

    // full countdown of ch0 from 1:02 with ch1 counting alongside
    idle_inputs();
    load = 2'b11; load_min = 6'd1; load_sec = 6'd2;
    step();
    idle_inputs();
    start[0] = 1'b1;
    step();
    idle_inputs();
    load[1] = 1'b1; load_min = 6'd0; load_sec = 6'd40;
    step();
    if (last_tick) ticks = 1; else ticks = 0;
    idle_inputs();
    start[1] = 1'b1;
    step();
    if (last_tick) ticks++;
    idle_inputs();
    seen = 0;
    for (int n = 0; n < 62 * TICK_DIV + 8 && !seen; n++) begin
      step();
      if (last_tick) ticks++;
      if (expired[0]) seen = 1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL expiry_timeout got=no_pulse want=pulse");
    end
    check("expiry_tick_count", W'(ticks), W'(62));
    step();
    check("done_held", dut_ch(0), {MIN_W'(0), 6'd0, 1'b0, 1'b1, 1'b0});

    // pause at 0:30, hold for 20 cycles, then resume
    load[0] = 1'b1; load_min = 6'd0; load_sec = 6'd32;
    step();
    idle_inputs();
    start[0] = 1'b1;
    step();
    idle_inputs();
    seen = 0;
    for (int n = 0; n < 4 * TICK_DIV && !seen; n++) begin
      step();
      if (count_seconds[5:0] == 6'd30) seen = 1;
    end
    pause[0] = 1'b1;
    step();
    idle_inputs();
    for (int n = 0; n < 20; n++) begin
      step();
      check("pause_hold", dut_ch(0), {MIN_W'(0), 6'd30, 1'b0, 1'b0, 1'b0});
    end
    start[0] = 1'b1;
    step();
    idle_inputs();
    seen = 0;
    for (int n = 0; n < TICK_DIV + 2 && !seen; n++) begin
      step();
      if (count_seconds[5:0] == 6'd29) seen = 1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL resume got=%0d want=29", count_seconds[5:0]);
    end

    // asynchronous reset while counting
    reset = 1'b1;
    #1;
    check("async_reset_ch0", dut_ch(0), '0);
    check("async_reset_ch1", dut_ch(1), '0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();

`ifdef TIMER_AUTORELOAD_EN
    auto_reload = 2'b01;
    load[0] = 1'b1; load_min = 6'd0; load_sec = 6'd3;
    step();
    idle_inputs();
    start[0] = 1'b1;
    step();
    idle_inputs();
    ticks = 0; pulses = 0; ar_ok = 1;
    for (int n = 0; n < 40; n++) begin
      step();
      if (last_tick) ticks++;
      if (expired[0]) pulses++;
      if (!running[0] || done[0]) ar_ok = 0;
    end
    check("ar_pulses", W'(pulses), W'(ticks / 3));
    check("ar_running", W'(ar_ok), W'(1));
    clear = 2'b11;
    step();
    idle_inputs();
`endif

    // random strobes against the model
    for (int n = 0; n < 800; n++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        load[c]  = ($urandom_range(0, 15) == 0);
        start[c] = ($urandom_range(0, 7) == 0);
        pause[c] = ($urandom_range(0, 23) == 0);
        clear[c] = ($urandom_range(0, 39) == 0);
      end
      load_min = MIN_W'($urandom_range(0, 2));
      load_sec = 6'($urandom_range(0, 63));
`ifdef TIMER_AUTORELOAD_EN
      if ($urandom_range(0, 31) == 0) auto_reload = NUM_CH'($urandom_range(0, 3));
`endif
      step();
    end
    idle_inputs();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
